// File: rtl/fb_pkg.sv
// Framebuffer constants and pixel entry layout shared with the upstream pattern generators.
package fb_pkg;

  localparam int H_PIX   = 160;
  localparam int V_PIX   = 120;
  localparam int ADDR_W  = 15;
  localparam int COLOR_W = 12;
  localparam int COORD_W = 8;
  localparam int ENTRY_W = 2 * COORD_W + COLOR_W;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module pixel_fifo #(
  parameter int DATA_W = 28,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Buffers pixel writes, range-checks and linearises coordinates, drives the framebuffer write port.
// Optional drop counter output enabled by FB_PIXEL_WRITER_STATS_EN.
module fb_pixel_writer #(
  parameter int H_PIX  = fb_pkg::H_PIX,
  parameter int V_PIX  = fb_pkg::V_PIX,
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_x,
  input  logic [7:0]        in_y,
  input  logic [11:0]       in_color,
  input  logic              fb_busy,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_data,
  output logic              fifo_empty
`ifdef FB_PIXEL_WRITER_STATS_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  import fb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] H_LIM = H_PIX;
  localparam logic [31:0] V_LIM = V_PIX;

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [7:0] x, input logic [7:0] y);
    logic [31:0] a;
    if (H_PIX == 160) a = ({24'd0, y} << 7) + ({24'd0, y} << 5) + {24'd0, x};
    else              a = {24'd0, y} * H_LIM + {24'd0, x};
    return a[ADDR_W-1:0];
  endfunction

  pixel_t           push_entry;
  pixel_t           head_p0;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             vld_p0;
  logic             in_range_p0;

  assign push_entry = '{x: in_x, y: in_y, color: in_color};
  assign in_ready   = !full;
  assign fifo_empty = empty;
  assign push       = in_valid && in_ready;
  assign vld_p0     = !empty && !fb_busy;

  pixel_fifo #(.DATA_W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (vld_p0),
    .dout  (head_p0),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign in_range_p0 = ({24'd0, head_p0.x} < H_LIM) && ({24'd0, head_p0.y} < V_LIM);

  // p0 -> p1: FIFO head popped into the framebuffer output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= vld_p0 && in_range_p0;
      if (vld_p0) begin
        fb_addr <= lin_addr(head_p0.x, head_p0.y);
        fb_data <= head_p0.color;
      end
    end
  end

`ifdef FB_PIXEL_WRITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else if (vld_p0 && !in_range_p0 && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Downstream stage of the pattern selector (clear / sine generator mux).
- Accepts pixel writes (x, y, 12-bit colour), buffers them in a small FIFO, converts coordinates to a linear address and drives the framebuffer RAM write port.
- Stalls when the scanout side holds the RAM busy.
- Drops off-screen coordinates.

Parameters:
- H_PIX, default 160: active pixels per line.
- V_PIX, default 120: active lines; framebuffer holds H_PIX*V_PIX = 19200 words.
- ADDR_W, default 15: framebuffer address width; must satisfy 2^ADDR_W >= H_PIX*V_PIX.
- DEPTH, default 4: FIFO entries, power of two, at least 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  FIFO can accept this cycle.
- in_x  in  8  pixel column.
- in_y  in  8  pixel row.
- in_color  in  12  RGB444 pixel colour.
- fb_busy  in  1  RAM port owned by scanout; no write may issue.
- fb_we  out  1  framebuffer write strobe, one cycle per pixel.
- fb_addr  out  ADDR_W  framebuffer word address.
- fb_data  out  12  framebuffer write data.
- fifo_empty  out  1  no pixels pending.

Behaviour:
- Reset:
  - Asynchronous on rst_n low; FIFO pointers and count go to 0.
  - fb_we=0, fb_addr=0, fb_data=0, in_ready=1, fifo_empty=1.
  - Reset mid-operation discards all queued pixels.
  - A write in flight is not completed: fb_we goes low immediately.
- Handshake:
  - in_ready = (count != DEPTH), combinational from registered count.
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - The upstream stage holds x, y and colour stable while valid && !ready.
- Push when full: in_ready is 0, so no push occurs even if a pop happens in the same cycle. There is no full-bypass.
- Pop: occurs on an edge where count != 0 and fb_busy == 0. There is no empty-bypass: a pixel pushed at edge N is first eligible to pop at edge N+1.
- Output register, updated on every edge:
  - fb_we <= pop && in_range.
  - On pop: fb_addr <= y*H_PIX + x and fb_data <= color.
  - Otherwise fb_addr and fb_data hold their previous values.
- Latency: with FIFO empty and fb_busy low, a pixel accepted at edge N is seen as fb_we=1 in the cycle after edge N+1. Sustained throughput is 1 pixel/clock.
- Range check: in_range = (x < H_PIX) && (y < V_PIX). Out-of-range entries are popped normally but produce fb_we=0.
- Address arithmetic:
  - Unsigned, computed at full width and then truncated to ADDR_W.
  - For H_PIX=160 it is implemented as (y<<7)+(y<<5)+x; no multiplier.
  - Examples: x=159, y=119 gives 19199; x=0, y=0 gives 0.
- Simultaneous push and pop (0 < count < DEPTH): both occur and count is unchanged.
- fb_busy: while high, no pops occur, fb_we=0 and the FIFO fills. Release resumes pops on the next edge.
- Pointers wrap modulo DEPTH. count is ceil(log2(DEPTH+1)) bits wide.
- fifo_empty = (count == 0).

Optional Feature:
- Macro FB_PIXEL_WRITER_STATS_EN.
- When defined:
  - Adds output port drop_cnt, 16 bits.
  - Increments on each pop of an out-of-range entry.
  - Saturates at 16'hFFFF.
  - Resets to 0.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include fb_pkg holds: H_PIX, V_PIX, ADDR_W, the RGB444 colour width (12) and the coordinate width (8). The upstream pattern generators use the same constants.
- One sub-module, pixel_fifo: generic synchronous FIFO, data width 28 (x, y, colour), DEPTH entries, ports push/pop/full/empty/count.
- The top level keeps range check, address calculation and output register.

Test Plan:
- Reset mid-stream: push 3 pixels with fb_busy=1, then pulse rst_n low. Expect fifo_empty=1, in_ready=1, fb_we=0, and no writes after release.
- Single pixel: push x=5, y=2, color=12'hF00 at edge N with fb_busy=0. Expect fb_we=1, fb_addr=325, fb_data=12'hF00 in the cycle after edge N+1, and exactly one strobe.
- Corner addresses: push (0,0) then (159,119). Expect fb_addr 0 then 19199 on consecutive fb_we cycles.
- Backpressure: hold fb_busy=1 and push continuously. Expect in_ready=0 after 4 accepts. Release fb_busy: expect 4 writes in order on 4 consecutive cycles, then in_ready=1.
- Off-screen: push (160,0), (0,120) and (10,10). Expect a single fb_we, with addr 1610; drop_cnt=2 when the stats macro is defined.
- Streaming: push 19200 pixels of a full-screen clear, in_valid always high, fb_busy=0. Expect 19200 strobes, addresses 0 through 19199 in order, no gaps after the first write.
